lfsr_bcd_display: RTL and testbench

- Downstream consumer of the 8-bit LFSR output.
- On a single-cycle `step` request it captures the current LFSR byte and converts it to decimal BCD with an iterative shift-add-3 (double-dabble) engine, one bit per cycle.
- Drives active-low seven-segment patterns for the result, with leading-zero blanking, so the board can show the pseudo-random value in decimal.

---
 rtl/lfsr_bcd_display.sv | 130 +++++++++++++
 tb/tb_lfsr_bcd_display.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bcd_display.sv
// lfsr_bcd_display
// Captures an LFSR byte on request and converts it to decimal BCD with an
// iterative double-dabble engine, one bit per clock. The result drives
// active-low seven-segment patterns, with leading zeros blanked.
module lfsr_bcd_display #(
   parameter int W    = 8,
   parameter int NDIG = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                step,
   input  logic [W-1:0]        din,
   output logic                busy,
   output logic                done,
   output logic                valid,
   output logic [4*NDIG-1:0]   bcd,
   output logic [8*NDIG-1:0]   seg
);

   localparam int SW = 4 * NDIG;        // BCD scratch width
   localparam int CW = $clog2(W) + 1;   // bit counter width

   typedef enum logic {IDLE, CONV} state_t;

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   // {scratch BCD, binary} shifted together as one register.
   logic [SW+W-1:0]    sh_reg, sh_next;
   logic [SW-1:0]      scr_adj;
   logic [SW-1:0]      bcd_reg, bcd_next;
   logic               valid_reg, valid_next;
   logic               done_reg, done_next;

   // Per-nibble add-3 correction; nibbles are independent (no carry).
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
         assign scr_adj[4*gi +: 4] = (sh_reg[W + 4*gi +: 4] >= 4'd5) ?
                                     sh_reg[W + 4*gi +: 4] + 4'd3 :
                                     sh_reg[W + 4*gi +: 4];
      end
   endgenerate

   // State and datapath registers; reset discards any partial conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         sh_reg    <= '0;
         bcd_reg   <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sh_reg    <= sh_next;
         bcd_reg   <= bcd_next;
         valid_reg <= valid_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic: capture in IDLE, one adjust-and-shift per CONV cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sh_next    = sh_reg;
      bcd_next   = bcd_reg;
      valid_next = valid_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (step) begin
               sh_next    = {{SW{1'b0}}, din};
               cnt_next   = '0;
               valid_next = 1'b0;
               state_next = CONV;
            end
         end
         CONV: begin
            // The bit shifted out of the top is always zero for legal W/NDIG.
            sh_next  = {scr_adj, sh_reg[W-1:0]} << 1;
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(W - 1)) begin
               bcd_next   = sh_next[SW+W-1:W];
               valid_next = 1'b1;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy  = (state_reg == CONV);
   assign done  = done_reg;
   assign valid = valid_reg;
   assign bcd   = bcd_reg;

   // Active-low {dp,g,f,e,d,c,b,a}; non-decimal nibbles show blank.
   function automatic logic [7:0] seg_pat(input logic [3:0] n);
      case (n)
         4'd0:    seg_pat = 8'hC0;
         4'd1:    seg_pat = 8'hF9;
         4'd2:    seg_pat = 8'hA4;
         4'd3:    seg_pat = 8'hB0;
         4'd4:    seg_pat = 8'h99;
         4'd5:    seg_pat = 8'h92;
         4'd6:    seg_pat = 8'h82;
         4'd7:    seg_pat = 8'hF8;
         4'd8:    seg_pat = 8'h80;
         4'd9:    seg_pat = 8'h90;
         default: seg_pat = 8'hFF;
      endcase
   endfunction

   // Decode purely from registered bcd/valid so seg never leads bcd.
   // A digit above the units blanks when it and every higher digit is zero.
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_seg
         logic blank;
         if (gi == 0) begin : g_units
            assign blank = ~valid_reg;
         end else begin : g_upper
            assign blank = ~valid_reg | (bcd_reg[SW-1:4*gi] == '0);
         end
         assign seg[8*gi +: 8] = blank ? 8'hFF : seg_pat(bcd_reg[4*gi +: 4]);
      end
   endgenerate

endmodule

// File: tb/tb_lfsr_bcd_display.sv
// Testbench for lfsr_bcd_display: decimal-arithmetic reference model checked
// every cycle, plus literal expectations at each directed conversion.
module tb_lfsr_bcd_display;

   localparam int W    = 8;
   localparam int NDIG = 3;
   localparam logic [7:0] SEGT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        busy, done, valid;
   logic [11:0] bcd;
   logic [23:0] seg;

   int checks = 0;
   int errors = 0;
   int ndone  = 0;
   bit mon_en = 1'b0;

   lfsr_bcd_display #(.W(W), .NDIG(NDIG)) dut (
      .clk(clk), .rst(rst), .step(step), .din(din),
      .busy(busy), .done(done), .valid(valid), .bcd(bcd), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal digits of v as packed BCD.
   function automatic logic [11:0] exp_bcd(input int v);
      exp_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Digit i shows only if the number is at least 10^i (units always shown).
   function automatic logic [23:0] exp_seg(input int v, input bit vld);
      logic [23:0] r;
      int pw;
      r  = 24'hFFFFFF;
      pw = 1;
      for (int i = 0; i < NDIG; i++) begin
         if (vld && (i == 0 || v >= pw))
            r[8*i +: 8] = SEGT[(v / pw) % 10];
         pw = pw * 10;
      end
      return r;
   endfunction

   // Reference model: request accepted when not busy; result W edges later.
   bit m_busy = 0, m_valid = 0, m_done = 0;
   int m_left = 0, m_cap = 0, m_res = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_valid <= 0; m_done <= 0; m_left <= 0; m_res <= 0;
      end else if (!m_busy) begin
         m_done <= 0;
         if (step) begin
            m_busy <= 1; m_valid <= 0; m_left <= W; m_cap <= int'(din);
         end
      end else begin
         m_left <= m_left - 1;
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_busy <= 0; m_valid <= 1; m_res <= m_cap;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy",  {31'b0, busy},  {31'b0, m_busy});
         chk("done",  {31'b0, done},  {31'b0, m_done});
         chk("valid", {31'b0, valid}, {31'b0, m_valid});
         chk("bcd",   {20'b0, bcd},   {20'b0, exp_bcd(m_res)});
         chk("seg",   {8'b0, seg},    {8'b0, exp_seg(m_res, m_valid)});
         if (done === 1'b1) ndone++;
      end
   end

   // One conversion from an idle DUT; ends at the cycle done is high.
   task automatic conv(input logic [7:0] v, input logic [11:0] eb, input logic [23:0] es);
      step = 1'b1; din = v;
      @(negedge clk);
      step = 1'b0;
      chk("conv_busy", {31'b0, busy}, 32'd1);
      repeat (W) @(negedge clk);
      chk("conv_done", {31'b0, done}, 32'd1);
      chk("conv_bcd",  {20'b0, bcd},  {20'b0, eb});
      chk("conv_seg",  {8'b0, seg},   {8'b0, es});
      $display("conv din=%0d bcd=%03h seg=%06h", v, bcd, seg);
   endtask

   initial begin
      int nd0, prev, nd;

      // Reset and idle
      rst = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("idle_bcd", {20'b0, bcd}, 32'h000);
         chk("idle_seg", {8'b0, seg},  32'hFFFFFF);
      end
      $display("idle bcd=%03h seg=%06h", bcd, seg);

      // Directed conversions
      conv(8'hFF,   12'h255, 24'hA49292);
      conv(8'h00,   12'h000, 24'hFFFFC0);
      conv(8'h07,   12'h007, 24'hFFFFF8);
      conv(8'd100,  12'h100, 24'hF9C0C0);
      @(negedge clk);

      // step and din changes during CONV must be ignored
      nd0 = ndone;
      step = 1'b1; din = 8'd42;
      @(negedge clk);                     // after acceptance edge
      step = 1'b0;
      @(negedge clk);
      step = 1'b1; din = 8'd99;
      repeat (3) @(negedge clk);
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      chk("ign_done", {31'b0, done}, 32'd1);
      chk("ign_bcd",  {20'b0, bcd},  32'h042);
      chk("ign_seg",  {8'b0, seg},   32'hFF99A4);
      repeat (10) @(negedge clk);
      chk("ign_npulse", ndone - nd0, 32'd1);
      $display("ignore-test bcd=%03h pulses=%0d", bcd, ndone - nd0);

      // Continuous step: back-to-back conversions every W+1 cycles
      prev = -1; nd = 0;
      step = 1'b1; din = 8'd13;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (prev >= 0) chk("b2b_gap", c - prev, 32'd9);
            chk("b2b_bcd", {20'b0, bcd}, 32'h013);
            chk("b2b_seg", {8'b0, seg},  32'hFFF9B0);
            prev = c; nd++;
         end
      end
      step = 1'b0;
      chk("b2b_count", nd, 32'd5);
      $display("back-to-back pulses=%0d", nd);
      repeat (12) @(negedge clk);

      // Reset in the middle of a conversion
      step = 1'b1; din = 8'd55;
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy",  {31'b0, busy},  32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_bcd",   {20'b0, bcd},   32'h000);
      chk("rst_seg",   {8'b0, seg},    32'hFFFFFF);
      $display("mid-conv reset busy=%0b valid=%0b seg=%06h", busy, valid, seg);
      conv(8'd200, 12'h200, 24'hA4C0C0);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
